issue_scoreboard: RTL

Issue-stage scoreboard for the GPCore RV32IM pipeline. It sits between the instruction decoder and the execute stage and decides each cycle whether the decoded instruction may issue. It tracks pending register writes (RAW/WAW) and owns the single register-file write port through a writeback-slot shift register. It also serialises the iterative divider. Its `stall` output is the decoder's `stall` input: it freezes fetch/decode and forces `pcselect`.

---
 rtl/issue_scoreboard.sv | 118 +++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: RAW/WAW tracking, writeback-port slot reservation, divider serialisation.
// Latency: stall/issue_fire combinational from state and inputs; writeback lands L cycles after issue.
// Backpressure: stall holds the decoder; a stalled instruction is re-evaluated every cycle.
module issue_scoreboard #(
    parameter int SLOT_DEPTH = 40,
    parameter int ALU_LAT    = 1,
    parameter int LD_LAT     = 2,
    parameter int MUL_LAT    = 3,
    parameter int DIV_LAT    = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        use_rs1,
    input  logic        use_rs2,
    input  logic        we,
    input  logic [1:0]  unit,
    output logic        stall,
    output logic        issue_fire,
    output logic        muldiv_start,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] busy_mask
);

    localparam int LW = $clog2(SLOT_DEPTH);
    localparam int CW = $clog2(DIV_LAT + 1);
    // The divider counts its remaining busy cycles; it frees itself in its own writeback cycle.
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    if (SLOT_DEPTH < 2 ||
        ALU_LAT < 1 || ALU_LAT > SLOT_DEPTH - 1 ||
        LD_LAT  < 1 || LD_LAT  > SLOT_DEPTH - 1 ||
        MUL_LAT < 1 || MUL_LAT > SLOT_DEPTH - 1 ||
        DIV_LAT < 1 || DIV_LAT > SLOT_DEPTH - 1) begin : g_lat_check
        $error("issue_scoreboard: every latency must lie in 1..SLOT_DEPTH-1");
    end

    logic          slot_vld [SLOT_DEPTH];
    logic [4:0]    slot_rd  [SLOT_DEPTH];
    logic [31:0]   busy_q;
    logic [CW-1:0] div_cnt;

    logic [LW-1:0] lat;
    logic          writer;
    logic [31:0]   wb_clr;
    logic [31:0]   set_mask;
    logic [31:0]   eb;
    logic          raw_hit;
    logic          waw_hit;
    logic          port_hit;
    logic          div_busy;
    logic [31:0]   busy_next;

    always_comb begin
        case (unit)
            2'b00:   lat = LW'(ALU_LAT);
            2'b01:   lat = LW'(LD_LAT);
            2'b10:   lat = LW'(MUL_LAT);
            default: lat = LW'(DIV_LAT);
        endcase
    end

    assign writer    = we & (rd != 5'd0);

    // Outputs read as cleared while reset is held, even before the synchronous clear lands.
    assign wb_valid  = slot_vld[0] & ~reset;
    assign wb_rd     = wb_valid ? slot_rd[0] : 5'd0;
    assign busy_mask = reset ? 32'd0 : busy_q;

    // Write-through register file: the register retiring this cycle is already readable.
    assign wb_clr    = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign eb        = busy_mask & ~wb_clr;

    assign raw_hit   = (use_rs1 & eb[rs1]) | (use_rs2 & eb[rs2]);
    assign waw_hit   = writer & eb[rd];
    assign port_hit  = writer & slot_vld[lat];
    assign div_busy  = (unit == 2'b11) & (div_cnt != '0);

    assign stall        = issue_valid & (raw_hit | waw_hit | port_hit | div_busy);
    assign issue_fire   = issue_valid & ~stall;
    assign muldiv_start = issue_fire & unit[1];

    assign set_mask  = (issue_fire & writer) ? (32'd1 << rd) : 32'd0;
    assign busy_next = ((busy_q & ~wb_clr) | set_mask) & ~32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SLOT_DEPTH; k++) begin
                slot_vld[k] <= 1'b0;
                slot_rd[k]  <= 5'd0;
            end
            busy_q  <= 32'd0;
            div_cnt <= '0;
        end else begin
            for (int k = 0; k < SLOT_DEPTH - 1; k++) begin
                slot_vld[k] <= slot_vld[k+1];
                slot_rd[k]  <= slot_rd[k+1];
            end
            slot_vld[SLOT_DEPTH-1] <= 1'b0;
            slot_rd[SLOT_DEPTH-1]  <= 5'd0;
            if (issue_fire && writer) begin
                slot_vld[lat - LW'(1)] <= 1'b1;
                slot_rd[lat - LW'(1)]  <= rd;
            end
            busy_q <= busy_next;
            if (issue_fire && unit == 2'b11) begin
                div_cnt <= DIV_LOAD;
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - CW'(1);
            end
        end
    end

endmodule
